// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES-128 round sequencing controller:
// state encoding, default round constants, step identifiers and the
// Moore output decode used by the controller's output registers.
package aes_ctrl_pkg;

  localparam int AES128_NR      = 10;
  localparam int AES128_ROUND_W = 4;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LOAD       = 4'd1,
    ST_SUB_GO     = 4'd2,
    ST_SUB_WAIT   = 4'd3,
    ST_SHIFT_GO   = 4'd4,
    ST_SHIFT_WAIT = 4'd5,
    ST_MIX_GO     = 4'd6,
    ST_MIX_WAIT   = 4'd7,
    ST_ARK_GO     = 4'd8,
    ST_ARK_WAIT   = 4'd9,
    ST_DONE       = 4'd10
  } ctrl_state_e;

  // Round-step identifiers; the numeric value doubles as the unit index.
  typedef enum logic [1:0] {
    STEP_SUB   = 2'd0,
    STEP_SHIFT = 2'd1,
    STEP_MIX   = 2'd2,
    STEP_ARK   = 2'd3
  } step_e;

  typedef struct packed {
    logic done;
    logic busy;
    logic load_in;
    logic sub_start;
    logic shift_start;
    logic mix_start;
    logic ark_start;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_OUT_RST = '{
    done: 1'b0, busy: 1'b0, load_in: 1'b0, sub_start: 1'b0,
    shift_start: 1'b0, mix_start: 1'b0, ark_start: 1'b0
  };

  // Moore output pattern for a given state; every non-IDLE state is busy.
  function automatic ctrl_out_t decode_outputs(input ctrl_state_e st);
    ctrl_out_t o;
    o = CTRL_OUT_RST;
    o.busy = (st != ST_IDLE);
    case (st)
      ST_LOAD:     o.load_in     = 1'b1;
      ST_SUB_GO:   o.sub_start   = 1'b1;
      ST_SHIFT_GO: o.shift_start = 1'b1;
      ST_MIX_GO:   o.mix_start   = 1'b1;
      ST_ARK_GO:   o.ark_start   = 1'b1;
      ST_DONE:     o.done        = 1'b1;
      default:     o.done        = 1'b0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/aes_start_arm.sv
// Start level-to-accept qualifier. A level request is accepted once per
// rising level: after an accept, start must be sampled low before the
// next accept can happen, so a start held high never retriggers.
module aes_start_arm (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic idle,
  output logic accept
);

  logic armed_q;
  logic armed_d;
  logic accept_s;

  assign accept_s = idle & start & armed_q;
  assign accept   = accept_s;

  // Disarm on accept, re-arm on any edge that samples start low.
  always_comb begin
    if (accept_s) begin
      armed_d = 1'b0;
    end else if (!start) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end
  end

  // Armed flag register; comes out of reset ready to accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b1;
    end else begin
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencing controller. Issues one-cycle start pulses to
// the SubBytes, ShiftRows, MixColumns and AddRoundKey units in AES order,
// waiting on each unit's done, and publishes the round index.
// Optional watchdog: define AES_CTRL_TIMEOUT_EN to add the per-wait
// cycle counter and the sticky err output.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR          = AES128_NR,
  parameter int ROUND_W     = AES128_ROUND_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               done,
  output logic               busy,
  output logic               load_in,
  output logic [ROUND_W-1:0] round,
`ifdef AES_CTRL_TIMEOUT_EN
  output logic               err,
`endif
  output logic               sub_start,
  input  logic               sub_done,
  output logic               shift_start,
  input  logic               shift_done,
  output logic               mix_start,
  input  logic               mix_done,
  output logic               ark_start,
  input  logic               ark_done
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NR);
  localparam logic [ROUND_W-1:0] ROUND_ZERO = {ROUND_W{1'b0}};

  if ((1 << ROUND_W) <= NR) begin : g_bad_round_w
    $error("aes_round_ctrl: ROUND_W cannot hold NR");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("aes_round_ctrl: TIMEOUT_CYC must be positive");
  end

  ctrl_state_e        state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  ctrl_out_t          out_q, out_d;
  logic               accept_s;

  aes_start_arm u_start_arm (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .idle   (state_q == ST_IDLE),
    .accept (accept_s)
  );

`ifdef AES_CTRL_TIMEOUT_EN
  localparam int             TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            err_q, err_d;
`endif

  // Next-state, round counter and (optionally) watchdog logic.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
`ifdef AES_CTRL_TIMEOUT_EN
    wait_cnt_d = {TO_W{1'b0}};
    err_d      = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_LOAD;
`ifdef AES_CTRL_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD:     state_d = ST_ARK_GO;
      ST_SUB_GO:   state_d = ST_SUB_WAIT;
      ST_SHIFT_GO: state_d = ST_SHIFT_WAIT;
      ST_MIX_GO:   state_d = ST_MIX_WAIT;
      ST_ARK_GO:   state_d = ST_ARK_WAIT;
      ST_SUB_WAIT: begin
        if (sub_done) state_d = ST_SHIFT_GO;
        else          state_d = ST_SUB_WAIT;
      end
      ST_SHIFT_WAIT: begin
        // The final round has no MixColumns step.
        if (!shift_done)              state_d = ST_SHIFT_WAIT;
        else if (round_q == LAST_ROUND) state_d = ST_ARK_GO;
        else                          state_d = ST_MIX_GO;
      end
      ST_MIX_WAIT: begin
        if (mix_done) state_d = ST_ARK_GO;
        else          state_d = ST_MIX_WAIT;
      end
      ST_ARK_WAIT: begin
        if (!ark_done) begin
          state_d = ST_ARK_WAIT;
        end else if (round_q == LAST_ROUND) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SUB_GO;
          round_d = round_q + ROUND_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        round_d = ROUND_ZERO;
      end
      default: begin
        state_d = ST_IDLE;
        round_d = ROUND_ZERO;
      end
    endcase
`ifdef AES_CTRL_TIMEOUT_EN
    // Count cycles spent in a WAIT state without its done; abort on limit.
    if (state_q inside {ST_SUB_WAIT, ST_SHIFT_WAIT, ST_MIX_WAIT, ST_ARK_WAIT}
        && state_d == state_q) begin
      if (wait_cnt_q == TO_LAST) begin
        state_d = ST_IDLE;
        round_d = ROUND_ZERO;
        err_d   = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + TO_W'(1);
      end
    end else begin
      wait_cnt_d = {TO_W{1'b0}};
    end
`endif
    out_d = decode_outputs(state_d);
  end

  // Controller state, round index and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      round_q <= ROUND_ZERO;
      out_q   <= CTRL_OUT_RST;
`ifdef AES_CTRL_TIMEOUT_EN
      wait_cnt_q <= {TO_W{1'b0}};
      err_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      out_q   <= out_d;
`ifdef AES_CTRL_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign done        = out_q.done;
  assign busy        = out_q.busy;
  assign load_in     = out_q.load_in;
  assign round       = round_q;
  assign sub_start   = out_q.sub_start;
  assign shift_start = out_q.shift_start;
  assign mix_start   = out_q.mix_start;
  assign ark_start   = out_q.ark_start;
`ifdef AES_CTRL_TIMEOUT_EN
  assign err         = err_q;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: table of block runs with stub
// units of configurable/random latency, plus hand-written sequences for
// reset abort, start hold, busy-time start and (with the macro) watchdog.
module tb_aes_round_ctrl;
  import aes_ctrl_pkg::*;

  localparam int NR         = AES128_NR;
  localparam int RW         = AES128_ROUND_W;
  localparam int TB_TIMEOUT = 64;

  typedef struct { int unit; int rnd; } step_obs_t;
  typedef struct {
    string name;
    int    dly;      // 0 = random 1..20
    bit    stray;
    int    exp_sub, exp_shift, exp_mix, exp_ark;
    int    exp_lat;  // 0 = derive from the delays actually used
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic done, busy, load_in;
  logic [RW-1:0] round;
  logic sub_start, shift_start, mix_start, ark_start;
  logic sub_done = 1'b0, shift_done = 1'b0, mix_done = 1'b0, ark_done = 1'b0;
`ifdef AES_CTRL_TIMEOUT_EN
  logic err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cnt [4];
  int delay_cfg = 1;
  bit stray_en  = 1'b0;
  bit mix_mute  = 1'b0;
  int step_delays[$];
  step_obs_t obs[$];
  step_obs_t exp_seq[$];
  int n_done_tot = 0, n_load_tot = 0, n_multi = 0, n_stray = 0;
  int done_cyc = 0, load_cyc = 0;

  aes_round_ctrl #(.NR(NR), .ROUND_W(RW), .TIMEOUT_CYC(TB_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .done(done), .busy(busy), .load_in(load_in), .round(round),
`ifdef AES_CTRL_TIMEOUT_EN
    .err(err),
`endif
    .sub_start(sub_start), .sub_done(sub_done),
    .shift_start(shift_start), .shift_done(shift_done),
    .mix_start(mix_start), .mix_done(mix_done),
    .ark_start(ark_start), .ark_done(ark_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub units: answer each start with a one-cycle done after 'delay' cycles.
  always @(negedge clk) begin
    logic [3:0] st;
    logic [3:0] dn;
    int d;
    st = {ark_start, mix_start, shift_start, sub_start};
    dn = 4'b0;
    if (!rst_n) begin
      for (int u = 0; u < 4; u++) cnt[u] = 0;
    end else begin
      for (int u = 0; u < 4; u++) begin
        if (cnt[u] > 0) begin
          cnt[u]--;
          if (cnt[u] == 0) dn[u] = 1'b1;
        end
        if (st[u] && !(u == 2 && mix_mute)) begin
          d = (delay_cfg == 0) ? int'($urandom_range(20, 1)) : delay_cfg;
          cnt[u] = d;
          step_delays.push_back(d);
        end
      end
      // Stray MixColumns done while SubBytes is outstanding.
      if (stray_en && cnt[0] > 0 && $urandom_range(1, 0) == 1) begin
        dn[2] = 1'b1;
        n_stray++;
      end
    end
    {ark_done, mix_done, shift_done, sub_done} = dn;
  end

  // Monitor: record every start pulse with its round, count loads and dones.
  always @(negedge clk) begin
    if (rst_n) begin
      if (load_in) begin n_load_tot++; load_cyc = cyc; end
      if (done)    begin n_done_tot++; done_cyc = cyc; end
      if (int'(sub_start) + int'(shift_start) + int'(mix_start) + int'(ark_start) > 1) n_multi++;
      if (sub_start)   obs.push_back('{int'(STEP_SUB),   int'(round)});
      if (shift_start) obs.push_back('{int'(STEP_SHIFT), int'(round)});
      if (mix_start)   obs.push_back('{int'(STEP_MIX),   int'(round)});
      if (ark_start)   obs.push_back('{int'(STEP_ARK),   int'(round)});
    end
  end

  function automatic logic [10:0] outs();
    return {done, busy, load_in, round, sub_start, shift_start, mix_start, ark_start};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Wait (bounded) until the done total reaches 'target'.
  task automatic wait_done(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (n_done_tot < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (n_done_tot < target) check({name, "_timeout"}, n_done_tot, target);
  endtask

  // Run one block and check counts, order and latency against the model.
  task automatic run_block(input vec_t v);
    int ob, db, ld0, dn0, lat, exp_lat, mism;
    int cs[4];
    ob = obs.size(); db = step_delays.size();
    ld0 = n_load_tot; dn0 = n_done_tot;
    delay_cfg = v.dly; stray_en = v.stray;
    @(negedge clk) start = 1'b1;
    wait_done(dn0 + 1, 4000, v.name);
    check({v.name, "_done_cnt"}, n_done_tot - dn0, 1);
    check({v.name, "_load_cnt"}, n_load_tot - ld0, 1);
    lat = done_cyc - load_cyc + 1;
    if (v.exp_lat > 0) begin
      exp_lat = v.exp_lat;
    end else begin
      exp_lat = 2;
      for (int i = db; i < step_delays.size(); i++) exp_lat += 1 + step_delays[i];
    end
    check({v.name, "_latency"}, lat, exp_lat);
    for (int u = 0; u < 4; u++) cs[u] = 0;
    mism = (obs.size() - ob == exp_seq.size()) ? 0 : 1000;
    for (int i = ob; i < obs.size(); i++) begin
      cs[obs[i].unit]++;
      if (i - ob < exp_seq.size()) begin
        if (obs[i].unit != exp_seq[i - ob].unit || obs[i].rnd != exp_seq[i - ob].rnd) mism++;
      end
    end
    check({v.name, "_sub_cnt"},   cs[0], v.exp_sub);
    check({v.name, "_shift_cnt"}, cs[1], v.exp_shift);
    check({v.name, "_mix_cnt"},   cs[2], v.exp_mix);
    check({v.name, "_ark_cnt"},   cs[3], v.exp_ark);
    check({v.name, "_order_err"}, mism, 0);
    stray_en = 1'b0;
    @(negedge clk) start = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    vec_t vecs[5];
    vec_t rv;
    int ld0, dn0, k, gap, mix_last;

    // Reference step order: ARK@0, then SUB,SHIFT,MIX,ARK per round, no MIX in last.
    exp_seq.push_back('{int'(STEP_ARK), 0});
    for (int r = 1; r <= NR; r++) begin
      exp_seq.push_back('{int'(STEP_SUB), r});
      exp_seq.push_back('{int'(STEP_SHIFT), r});
      if (r < NR) exp_seq.push_back('{int'(STEP_MIX), r});
      exp_seq.push_back('{int'(STEP_ARK), r});
    end

    vecs[0] = '{"d1",        1, 1'b0, NR, NR, NR - 1, NR + 1, 82};
    vecs[1] = '{"d2",        2, 1'b0, NR, NR, NR - 1, NR + 1, 122};
    vecs[2] = '{"d3_stray",  3, 1'b1, NR, NR, NR - 1, NR + 1, 162};
    vecs[3] = '{"rnd",       0, 1'b0, NR, NR, NR - 1, NR + 1, 0};
    vecs[4] = '{"rnd_stray", 0, 1'b1, NR, NR, NR - 1, NR + 1, 0};

    // Reset state.
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", int'(outs()), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("idle_after_reset", int'(outs()), 0);

    // Table-driven block runs.
    for (int i = 0; i < 5; i++) run_block(vecs[i]);

    // Randomised block runs.
    for (int i = 0; i < 4; i++) begin
      rv = '{"rand_loop", 0, 1'($urandom_range(1, 0)), NR, NR, NR - 1, NR + 1, 0};
      run_block(rv);
    end

    // Start held high for 15000 ns: exactly one block, then re-arm on a low.
    delay_cfg = 1; ld0 = n_load_tot; dn0 = n_done_tot;
    @(negedge clk) start = 1'b1;
    repeat (1500) @(posedge clk);
    check("hold_done_cnt", n_done_tot - dn0, 1);
    check("hold_load_cnt", n_load_tot - ld0, 1);
    check("hold_latency", done_cyc - load_cyc + 1, 82);
    @(negedge clk) start = 1'b0;
    @(negedge clk) start = 1'b1;
    repeat (5) @(posedge clk);
    check("rearm_load_cnt", n_load_tot - ld0, 2);
    wait_done(dn0 + 2, 300, "rearm");
    check("rearm_done_cnt", n_done_tot - dn0, 2);
    @(negedge clk) start = 1'b0;
    repeat (3) @(posedge clk);

    // Start dropped and re-raised while busy: no accept until back in IDLE.
    ld0 = n_load_tot; dn0 = n_done_tot;
    @(negedge clk) start = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk) start = 1'b0;
    @(negedge clk) start = 1'b1;
    wait_done(dn0 + 1, 300, "busy_start");
    check("busy_start_ignored", n_load_tot - ld0, 1);
    gap = 0; k = 0;
    do begin
      @(negedge clk);
      if (!busy) gap++;
      k++;
    end while (!load_in && k < 10);
    check("busy_gap", gap, 1);
    check("back_to_back_load", int'(load_in), 1);

    // Reset in the middle of the second block at round 3.
    k = 0;
    while (round != RW'(3) && k < 300) begin
      @(posedge clk);
      k++;
    end
    check("reach_round3", int'(round), 3);
    dn0 = n_done_tot;
    #3 rst_n = 1'b0; start = 1'b0;
    #1 check("async_reset_outputs", int'(outs()), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1 check("abort_no_done", n_done_tot - dn0, 0);
    check("abort_idle_outputs", int'(outs()), 0);

`ifdef AES_CTRL_TIMEOUT_EN
    // Watchdog: MixColumns never answers.
    dn0 = n_done_tot; mix_mute = 1'b1; delay_cfg = 1;
    @(negedge clk) start = 1'b1;
    k = 0;
    while (!mix_start && k < 50) begin @(negedge clk); k++; end
    mix_last = cyc;
    k = 0;
    while (!err && k < TB_TIMEOUT + 50) begin @(negedge clk); k++; end
    check("wd_err", int'(err), 1);
    check("wd_wait_cycles", cyc - mix_last, TB_TIMEOUT + 1);
    check("wd_idle", int'(busy), 0);
    check("wd_round", int'(round), 0);
    check("wd_no_done", n_done_tot - dn0, 0);
    mix_mute = 1'b0;
    @(negedge clk) start = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    check("wd_reload", int'(load_in), 1);
    check("wd_err_cleared", int'(err), 0);
    wait_done(dn0 + 1, 300, "wd_recover");
    @(negedge clk) start = 1'b0;
    repeat (3) @(posedge clk);
`endif

    // Global properties over everything observed.
    mix_last = 0;
    foreach (obs[i]) if (obs[i].unit == int'(STEP_MIX) && obs[i].rnd == NR) mix_last++;
    check("mix_at_last_round", mix_last, 0);
    check("overlapping_starts", n_multi, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
